// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers,
//            with a pipeline stall interlock while an operation is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    input  logic             hiWrEn,
    input  logic             loWrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             hiLoRead,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_opB;
    logic                 r_resNeg;
    logic                 r_remNeg;
    logic                 r_isDiv;
    logic                 r_divZero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_signed;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic                 w_last;
    logic [WIDTH:0]       w_mulSum;
    logic [WIDTH:0]       w_divShift;
    logic [WIDTH:0]       w_divDiff;
    logic                 w_divQbit;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_remFix;

    assign w_signed = ~op[0];
    assign w_absA   = (w_signed && srcA[WIDTH-1]) ? -srcA : srcA;
    assign w_absB   = (w_signed && srcB[WIDTH-1]) ? -srcB : srcB;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply: multiplier sits in the low half and shifts out LSB-first while
    // partial sums (with carry) enter from the top.
    assign w_mulSum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opB} : '0);

    // Divide: dividend bits shift out of the acc MSB into the remainder while
    // quotient bits enter at the LSB; bit WIDTH of the difference is the borrow.
    assign w_divShift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_opB};
    assign w_divQbit  = ~w_divDiff[WIDTH];

    assign w_prod   = r_resNeg ? -r_acc : r_acc;
    assign w_quo    = r_divZero ? '1 : (r_resNeg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_remFix = r_remNeg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && !flush) w_next = S_RUN;
            S_RUN: begin
                if (flush)       w_next = S_IDLE;
                else if (w_last) w_next = S_FIN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_opB     <= '0;
            r_resNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!flush && start) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_absA : w_absB)};
                        r_opB     <= op[1] ? w_absB : w_absA;
                        r_resNeg  <= w_signed & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        r_remNeg  <= w_signed & srcA[WIDTH-1];
                        r_isDiv   <= op[1];
                        r_divZero <= op[1] & (srcB == '0);
                    end else if (!flush) begin
                        if (hiWrEn) r_hi <= wrData;
                        if (loWrEn) r_lo <= wrData;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_isDiv) begin
                            r_rem <= w_divQbit ? w_divDiff : w_divShift;
                            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_divQbit};
                        end else begin
                            r_acc <= {w_mulSum, r_acc[WIDTH-1:1]};
                        end
                    end
                end
                S_FIN: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_isDiv) begin
                            r_hi <= w_remFix;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hiOut = r_hi;
    assign loOut = r_lo;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign stall = busy & (start | hiLoRead | hiWrEn | loWrEn);

endmodule
`default_nettype wire
